// File: rtl/fdtd_ez_select_pipe_if.sv
// Handshake/data bundle for the N-channel Ez selector: input beat, queued result, error status.
interface fdtd_ez_select_pipe_if #(
  parameter int unsigned FDTD_DATA_WIDTH = 80,
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned ERR_CNT_WIDTH   = 16
);
  logic [NUM_CH-1:0]                 ch_en;
  logic                              mode_add;
  logic [NUM_CH*FDTD_DATA_WIDTH-1:0] ez_in;
  logic                              in_valid;
  logic                              in_ready;
  logic signed [FDTD_DATA_WIDTH-1:0] ez_out;
  logic                              out_valid;
  logic                              out_ready;
  logic                              sel_err;
  logic                              err_clr;
  logic [ERR_CNT_WIDTH-1:0]          err_cnt;

  modport master (
    output ch_en, mode_add, ez_in, in_valid, out_ready, err_clr,
    input  in_ready, ez_out, out_valid, sel_err, err_cnt
  );

  modport slave (
    input  ch_en, mode_add, ez_in, in_valid, out_ready, err_clr,
    output in_ready, ez_out, out_valid, sel_err, err_cnt
  );
endinterface

// File: rtl/fdtd_ez_select_pipe.sv
// N-channel Ez select/saturating-add stage with a 2-entry valid/ready output queue.
// Optional error-beat counter enabled by defining FDTD_SEL_ERR_CNT_EN.
module fdtd_ez_select_pipe #(
  parameter int unsigned FDTD_DATA_WIDTH = 80,
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned ERR_CNT_WIDTH   = 16
) (
  input logic               clk,
  input logic               rst,
  fdtd_ez_select_pipe_if.slave bus
);

  localparam int unsigned W  = FDTD_DATA_WIDTH;
  localparam int unsigned SW = W + $clog2(NUM_CH);
  localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t                state, state_n;
  logic signed [W-1:0]   head, head_n;
  logic signed [W-1:0]   tail, tail_n;
  logic signed [W-1:0]   sel_val;
  logic signed [SW-1:0]  sum;
  logic signed [W-1:0]   result;
  logic                  sum_ovf;
  logic                  multi_en;
  logic                  push;
  logic                  pop;
  logic                  err_beat;

  assign bus.in_ready  = (state != FULL) && !rst;
  assign bus.out_valid = (state != EMPTY);
  assign bus.ez_out    = head;

  assign push     = bus.in_valid && bus.in_ready;
  assign pop      = bus.out_valid && bus.out_ready;
  assign multi_en = (bus.ch_en & (bus.ch_en - NUM_CH'(1))) != '0;
  assign err_beat = push && !bus.mode_add && multi_en;

  // Lowest-index enabled channel wins: scan downward so the last hit is the lowest.
  always_comb begin
    sel_val = '0;
    for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
      if (bus.ch_en[k]) sel_val = bus.ez_in[k*W +: W];
    end
  end

  // Sum with clog2(NUM_CH) guard bits, so overflow shows up as non-uniform top bits.
  always_comb begin
    sum = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (bus.ch_en[k]) sum = sum + SW'(signed'(bus.ez_in[k*W +: W]));
    end
  end

  assign sum_ovf = !((&sum[SW-1:W-1]) || !(|sum[SW-1:W-1]));

  always_comb begin
    result = sel_val;
    if (bus.mode_add) begin
      if (sum_ovf) result = sum[SW-1] ? MIN_V : MAX_V;
      else         result = sum[W-1:0];
    end
  end

  // Queue occupancy FSM; head is cleared when the queue empties so ez_out reads 0.
  always_comb begin
    state_n = state;
    head_n  = head;
    tail_n  = tail;
    case (state)
      EMPTY: begin
        if (push) begin
          state_n = ONE;
          head_n  = result;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_n = result;
        end else if (pop) begin
          state_n = EMPTY;
          head_n  = '0;
        end else if (push) begin
          state_n = FULL;
          tail_n  = result;
        end
      end
      FULL: begin
        if (pop) begin
          state_n = ONE;
          head_n  = tail;
          tail_n  = '0;
        end
      end
      default: begin
        state_n = EMPTY;
        head_n  = '0;
        tail_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_n;
      head  <= head_n;
      tail  <= tail_n;
    end
  end

  // Sticky error: a new error beat beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)           bus.sel_err <= 1'b0;
    else if (err_beat) bus.sel_err <= 1'b1;
    else if (bus.err_clr) bus.sel_err <= 1'b0;
  end

`ifdef FDTD_SEL_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.err_cnt <= '0;
    end else if (bus.err_clr) begin
      bus.err_cnt <= err_beat ? ERR_CNT_WIDTH'(1) : '0;
    end else if (err_beat && (bus.err_cnt != '1)) begin
      bus.err_cnt <= bus.err_cnt + ERR_CNT_WIDTH'(1);
    end
  end
`else
  assign bus.err_cnt = ERR_CNT_WIDTH'(0);
`endif

endmodule
